// File: rtl/alu_reservation_station.sv
// Reservation station in front of the ALU: a compacted in-order queue that captures operands
// from two wakeup buses and issues the oldest entry whose operands are both ready.
module alu_reservation_station #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       dispatch_valid,
  output logic                       dispatch_ready,
  input  logic [3:0]                 dispatch_ALUControl,
  input  logic                       dispatch_ALUSrc,
  input  logic                       dispatch_is_for_lsq,
  input  logic [31:0]                dispatch_imm,
  input  logic                       dispatch_rs1_ready,
  input  logic                       dispatch_rs2_ready,
  input  logic [5:0]                 dispatch_rs1_tag,
  input  logic [5:0]                 dispatch_rs2_tag,
  input  logic [31:0]                dispatch_rs1_value,
  input  logic [31:0]                dispatch_rs2_value,
  input  logic [5:0]                 dispatch_tag_to_output,
  input  logic [5:0]                 dispatch_rob_index,
  input  logic [1:0]                 wakeup_active,
  input  logic [11:0]                wakeup_tag,
  input  logic [63:0]                wakeup_value,
  input  logic                       fu_available,
  output logic                       issue_write_enable,
  output logic [3:0]                 issue_ALUControl,
  output logic                       issue_ALUSrc,
  output logic                       issue_is_for_lsq,
  output logic [31:0]                issue_imm,
  output logic [31:0]                issue_rs1_value,
  output logic [31:0]                issue_rs2_value,
  output logic [5:0]                 issue_tag_to_output,
  output logic [5:0]                 issue_rob_index,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Handshakes: an op is taken on an edge with dispatch_valid & dispatch_ready; the FU takes an
  // op on an edge with issue_write_enable high, and that same edge removes it from the queue.

  logic [3:0]  e_ctrl    [DEPTH];
  logic        e_src     [DEPTH];
  logic        e_lsq     [DEPTH];
  logic [31:0] e_imm     [DEPTH];
  logic        e_r1_rdy  [DEPTH];
  logic [5:0]  e_r1_tag  [DEPTH];
  logic [31:0] e_r1_val  [DEPTH];
  logic        e_r2_rdy  [DEPTH];
  logic [5:0]  e_r2_tag  [DEPTH];
  logic [31:0] e_r2_val  [DEPTH];
  logic [5:0]  e_dst     [DEPTH];
  logic [5:0]  e_rob     [DEPTH];

  logic        c_r1_rdy  [DEPTH];
  logic [31:0] c_r1_val  [DEPTH];
  logic        c_r2_rdy  [DEPTH];
  logic [31:0] c_r2_val  [DEPTH];
  logic [IW-1:0] src_idx [DEPTH];

  logic          d_r1_rdy, d_r2_rdy;
  logic [31:0]   d_r1_val, d_r2_val;
  logic          any_eligible, do_issue, accept;
  logic [IW-1:0] sel_idx, wr_idx;

  // Bus 0 has priority when both buses carry the awaited tag.
  function automatic logic [32:0] capture(input logic rdy, input logic [5:0] tag,
                                          input logic [31:0] val, input logic [1:0] act,
                                          input logic [11:0] wtag, input logic [63:0] wval);
    logic [32:0] r;
    r = {rdy, val};
    if (!rdy) begin
      if (act[0] && wtag[5:0] == tag)       r = {1'b1, wval[31:0]};
      else if (act[1] && wtag[11:6] == tag) r = {1'b1, wval[63:32]};
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {c_r1_rdy[i], c_r1_val[i]} = capture(e_r1_rdy[i], e_r1_tag[i], e_r1_val[i],
                                           wakeup_active, wakeup_tag, wakeup_value);
      {c_r2_rdy[i], c_r2_val[i]} = capture(e_r2_rdy[i], e_r2_tag[i], e_r2_val[i],
                                           wakeup_active, wakeup_tag, wakeup_value);
    end
    {d_r1_rdy, d_r1_val} = capture(dispatch_rs1_ready, dispatch_rs1_tag, dispatch_rs1_value,
                                   wakeup_active, wakeup_tag, wakeup_value);
    {d_r2_rdy, d_r2_val} = capture(dispatch_rs2_ready | dispatch_ALUSrc, dispatch_rs2_tag,
                                   dispatch_rs2_value, wakeup_active, wakeup_tag, wakeup_value);
  end

  // Scan from the top so the lowest-index eligible entry wins.
  always_comb begin
    any_eligible = 1'b0;
    sel_idx      = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (CW'(i) < count && e_r1_rdy[i] && e_r2_rdy[i]) begin
        any_eligible = 1'b1;
        sel_idx      = IW'(i);
      end
    end
  end

  assign dispatch_ready     = (count != CW'(DEPTH));
  assign accept             = dispatch_valid & dispatch_ready;
  assign issue_write_enable = fu_available & any_eligible & ~flush;
  assign do_issue           = issue_write_enable;
  assign wr_idx             = IW'(count - CW'(do_issue));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      src_idx[i] = (do_issue && IW'(i) >= sel_idx && i < DEPTH-1) ? IW'(i+1) : IW'(i);
    end
  end

  always_comb begin
    issue_ALUControl    = '0;
    issue_ALUSrc        = 1'b0;
    issue_is_for_lsq    = 1'b0;
    issue_imm           = '0;
    issue_rs1_value     = '0;
    issue_rs2_value     = '0;
    issue_tag_to_output = '0;
    issue_rob_index     = '0;
    if (issue_write_enable) begin
      issue_ALUControl    = e_ctrl[sel_idx];
      issue_ALUSrc        = e_src[sel_idx];
      issue_is_for_lsq    = e_lsq[sel_idx];
      issue_imm           = e_imm[sel_idx];
      issue_rs1_value     = e_r1_val[sel_idx];
      issue_rs2_value     = e_r2_val[sel_idx];
      issue_tag_to_output = e_dst[sel_idx];
      issue_rob_index     = e_rob[sel_idx];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_ctrl[i]   <= '0;
        e_src[i]    <= 1'b0;
        e_lsq[i]    <= 1'b0;
        e_imm[i]    <= '0;
        e_r1_rdy[i] <= 1'b0;
        e_r1_tag[i] <= '0;
        e_r1_val[i] <= '0;
        e_r2_rdy[i] <= 1'b0;
        e_r2_tag[i] <= '0;
        e_r2_val[i] <= '0;
        e_dst[i]    <= '0;
        e_rob[i]    <= '0;
      end
    end else if (flush) begin
      count <= '0;
    end else begin
      // Shift-down and operand capture compose: each slot takes its source's captured operands.
      for (int i = 0; i < DEPTH; i++) begin
        e_ctrl[i]   <= e_ctrl[src_idx[i]];
        e_src[i]    <= e_src[src_idx[i]];
        e_lsq[i]    <= e_lsq[src_idx[i]];
        e_imm[i]    <= e_imm[src_idx[i]];
        e_r1_rdy[i] <= c_r1_rdy[src_idx[i]];
        e_r1_tag[i] <= e_r1_tag[src_idx[i]];
        e_r1_val[i] <= c_r1_val[src_idx[i]];
        e_r2_rdy[i] <= c_r2_rdy[src_idx[i]];
        e_r2_tag[i] <= e_r2_tag[src_idx[i]];
        e_r2_val[i] <= c_r2_val[src_idx[i]];
        e_dst[i]    <= e_dst[src_idx[i]];
        e_rob[i]    <= e_rob[src_idx[i]];
      end
      if (accept) begin
        e_ctrl[wr_idx]   <= dispatch_ALUControl;
        e_src[wr_idx]    <= dispatch_ALUSrc;
        e_lsq[wr_idx]    <= dispatch_is_for_lsq;
        e_imm[wr_idx]    <= dispatch_imm;
        e_r1_rdy[wr_idx] <= d_r1_rdy;
        e_r1_tag[wr_idx] <= dispatch_rs1_tag;
        e_r1_val[wr_idx] <= d_r1_val;
        e_r2_rdy[wr_idx] <= d_r2_rdy;
        e_r2_tag[wr_idx] <= dispatch_rs2_tag;
        e_r2_val[wr_idx] <= d_r2_val;
        e_dst[wr_idx]    <= dispatch_tag_to_output;
        e_rob[wr_idx]    <= dispatch_rob_index;
      end
      count <= count + CW'(accept) - CW'(do_issue);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && dispatch_valid) begin
      assert (dispatch_ready) else $fatal(1, "dispatch while station is full");
      assert (dispatch_ALUControl inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1011, 4'b1111})
        else $fatal(1, "illegal dispatch_ALUControl %b", dispatch_ALUControl);
    end
  end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios then random traffic, all checked against
// a queue-based reference model of the station.
module tb_alu_reservation_station;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int BW    = 114;

  logic clk, reset_n, flush, dispatch_valid, dispatch_ready;
  logic [3:0] dispatch_ALUControl;
  logic dispatch_ALUSrc, dispatch_is_for_lsq, dispatch_rs1_ready, dispatch_rs2_ready;
  logic [31:0] dispatch_imm, dispatch_rs1_value, dispatch_rs2_value;
  logic [5:0] dispatch_rs1_tag, dispatch_rs2_tag, dispatch_tag_to_output, dispatch_rob_index;
  logic [1:0] wakeup_active;
  logic [11:0] wakeup_tag;
  logic [63:0] wakeup_value;
  logic fu_available, issue_write_enable, issue_ALUSrc, issue_is_for_lsq;
  logic [3:0] issue_ALUControl;
  logic [31:0] issue_imm, issue_rs1_value, issue_rs2_value;
  logic [5:0] issue_tag_to_output, issue_rob_index;
  logic [CW-1:0] count;
  logic [BW-1:0] dut_bundle;

  alu_reservation_station #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_ALUControl(dispatch_ALUControl), .dispatch_ALUSrc(dispatch_ALUSrc),
    .dispatch_is_for_lsq(dispatch_is_for_lsq), .dispatch_imm(dispatch_imm),
    .dispatch_rs1_ready(dispatch_rs1_ready), .dispatch_rs2_ready(dispatch_rs2_ready),
    .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs2_tag(dispatch_rs2_tag),
    .dispatch_rs1_value(dispatch_rs1_value), .dispatch_rs2_value(dispatch_rs2_value),
    .dispatch_tag_to_output(dispatch_tag_to_output), .dispatch_rob_index(dispatch_rob_index),
    .wakeup_active(wakeup_active), .wakeup_tag(wakeup_tag), .wakeup_value(wakeup_value),
    .fu_available(fu_available), .issue_write_enable(issue_write_enable),
    .issue_ALUControl(issue_ALUControl), .issue_ALUSrc(issue_ALUSrc),
    .issue_is_for_lsq(issue_is_for_lsq), .issue_imm(issue_imm),
    .issue_rs1_value(issue_rs1_value), .issue_rs2_value(issue_rs2_value),
    .issue_tag_to_output(issue_tag_to_output), .issue_rob_index(issue_rob_index),
    .count(count)
  );

  assign dut_bundle = {issue_ALUControl, issue_ALUSrc, issue_is_for_lsq, issue_imm,
                       issue_rs1_value, issue_rs2_value, issue_tag_to_output, issue_rob_index};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: the station as a plain ordered queue of ops
  typedef struct {
    logic [3:0] ctrl; logic src; logic lsq; logic [31:0] imm;
    logic r1_rdy; logic [5:0] r1_tag; logic [31:0] r1_val;
    logic r2_rdy; logic [5:0] r2_tag; logic [31:0] r2_val;
    logic [5:0] dst; logic [5:0] rob;
  } ent_t;

  ent_t          model_q[$];
  logic [BW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  logic [3:0] legal_ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1011, 4'b1111};

  task automatic chk(input string name, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic ent_t wake(input ent_t e);
    ent_t r = e;
    if (!r.r1_rdy && wakeup_active[0] && wakeup_tag[5:0] == r.r1_tag) begin
      r.r1_rdy = 1'b1; r.r1_val = wakeup_value[31:0];
    end else if (!r.r1_rdy && wakeup_active[1] && wakeup_tag[11:6] == r.r1_tag) begin
      r.r1_rdy = 1'b1; r.r1_val = wakeup_value[63:32];
    end
    if (!r.r2_rdy && wakeup_active[0] && wakeup_tag[5:0] == r.r2_tag) begin
      r.r2_rdy = 1'b1; r.r2_val = wakeup_value[31:0];
    end else if (!r.r2_rdy && wakeup_active[1] && wakeup_tag[11:6] == r.r2_tag) begin
      r.r2_rdy = 1'b1; r.r2_val = wakeup_value[63:32];
    end
    return r;
  endfunction

  function automatic int model_sel();
    foreach (model_q[i]) if (model_q[i].r1_rdy && model_q[i].r2_rdy) return i;
    return -1;
  endfunction

  function automatic logic [BW-1:0] pack(input ent_t e);
    return {e.ctrl, e.src, e.lsq, e.imm, e.r1_val, e.r2_val, e.dst, e.rob};
  endfunction

  task automatic check_outputs();
    int s;
    logic exp_we;
    s = model_sel();
    exp_we = fu_available && (s >= 0) && !flush;
    chk("count", BW'(count), BW'(model_q.size()));
    chk("dispatch_ready", BW'(dispatch_ready), BW'(model_q.size() != DEPTH));
    chk("issue_write_enable", BW'(issue_write_enable), BW'(exp_we));
    exp_q.push_back(exp_we ? pack(model_q[s]) : '0);
    chk("issue_fields", dut_bundle, exp_q.pop_front());
  endtask

  task automatic model_update();
    int s;
    logic we;
    ent_t n;
    s  = model_sel();
    we = fu_available && (s >= 0) && !flush;
    if (flush) begin
      model_q.delete();
    end else begin
      foreach (model_q[i]) model_q[i] = wake(model_q[i]);
      if (we) model_q.delete(s);
      if (dispatch_valid) begin
        n.ctrl = dispatch_ALUControl; n.src = dispatch_ALUSrc; n.lsq = dispatch_is_for_lsq;
        n.imm = dispatch_imm;
        n.r1_rdy = dispatch_rs1_ready; n.r1_tag = dispatch_rs1_tag; n.r1_val = dispatch_rs1_value;
        n.r2_rdy = dispatch_rs2_ready || dispatch_ALUSrc;
        n.r2_tag = dispatch_rs2_tag; n.r2_val = dispatch_rs2_value;
        n.dst = dispatch_tag_to_output; n.rob = dispatch_rob_index;
        model_q.push_back(wake(n));
      end
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    #1;
    check_outputs();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drivers
  task automatic idle();
    dispatch_valid = 1'b0; wakeup_active = 2'b00; flush = 1'b0;
  endtask

  task automatic drive_op(input logic [3:0] ctrl, input logic src,
                          input logic r1_rdy, input logic [5:0] r1_tag, input logic [31:0] r1_val,
                          input logic r2_rdy, input logic [5:0] r2_tag, input logic [31:0] r2_val,
                          input logic [5:0] dst, input logic [5:0] rob);
    dispatch_valid = 1'b1; dispatch_ALUControl = ctrl; dispatch_ALUSrc = src;
    dispatch_is_for_lsq = 1'($urandom_range(0, 1)); dispatch_imm = $urandom;
    dispatch_rs1_ready = r1_rdy; dispatch_rs1_tag = r1_tag; dispatch_rs1_value = r1_val;
    dispatch_rs2_ready = r2_rdy; dispatch_rs2_tag = r2_tag; dispatch_rs2_value = r2_val;
    dispatch_tag_to_output = dst; dispatch_rob_index = rob;
  endtask

  initial begin
    reset_n = 1'b0; fu_available = 1'b0;
    drive_op(4'b0000, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    idle();
    #2;
    chk("reset_count", BW'(count), '0);
    chk("reset_ready", BW'(dispatch_ready), BW'(1));
    chk("reset_we", BW'(issue_write_enable), '0);
    chk("reset_fields", dut_bundle, '0);
    @(negedge clk);
    reset_n = 1'b1;

    // Ready operands: issue the cycle after dispatch
    drive_op(4'b0010, 1'b0, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7, 6'd9, 6'd3);
    fu_available = 1'b1;
    cycle();
    idle();
    #1;
    chk("t1_we", BW'(issue_write_enable), BW'(1));
    chk("t1_rs1", BW'(issue_rs1_value), BW'(32'd5));
    chk("t1_rs2", BW'(issue_rs2_value), BW'(32'd7));
    chk("t1_tag", BW'(issue_tag_to_output), BW'(6'd9));
    chk("t1_rob", BW'(issue_rob_index), BW'(6'd3));
    cycle();
    #1;
    chk("t1_count_zero", BW'(count), '0);

    // Wakeup capture from bus 1
    drive_op(4'b0011, 1'b0, 1'b0, 6'd12, 32'd0, 1'b1, 6'd0, 32'd1, 6'd10, 6'd4);
    cycle();
    idle();
    #1;
    chk("t2_waiting", BW'(issue_write_enable), '0);
    cycle();
    wakeup_active = 2'b10; wakeup_tag = {6'd12, 6'd0}; wakeup_value = {32'hF0, 32'h0};
    #1;
    chk("t2_broadcast_no_bypass", BW'(issue_write_enable), '0);
    cycle();
    idle();
    #1;
    chk("t2_we", BW'(issue_write_enable), BW'(1));
    chk("t2_rs1", BW'(issue_rs1_value), BW'(32'hF0));
    cycle();

    // Dispatch/wakeup race on bus 0
    drive_op(4'b0010, 1'b0, 1'b1, 6'd0, 32'd1, 1'b0, 6'd20, 32'd0, 6'd11, 6'd5);
    wakeup_active = 2'b01; wakeup_tag = {6'd0, 6'd20}; wakeup_value = {32'h0, 32'h33};
    cycle();
    idle();
    #1;
    chk("t3_we", BW'(issue_write_enable), BW'(1));
    chk("t3_rs2", BW'(issue_rs2_value), BW'(32'h33));
    cycle();

    // Fill, then wake entries 5 and 2: oldest-first issue and shift
    fu_available = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      drive_op(4'b0000, 1'b0, 1'b0, 6'(40 + k), 32'd0, 1'b1, 6'd0, 32'(k), 6'(16 + k), 6'(k));
      cycle();
    end
    idle();
    #1;
    chk("t4_full_ready", BW'(dispatch_ready), '0);
    chk("t4_full_count", BW'(count), BW'(DEPTH));
    cycle();
    wakeup_active = 2'b01; wakeup_tag = {6'd0, 6'd45}; wakeup_value = {32'h0, 32'h500};
    cycle();
    wakeup_tag = {6'd0, 6'd42}; wakeup_value = {32'h0, 32'h200};
    cycle();
    idle();
    fu_available = 1'b1;
    #1;
    chk("t4_first_rob", BW'(issue_rob_index), BW'(6'd2));
    cycle();
    #1;
    chk("t4_second_rob", BW'(issue_rob_index), BW'(6'd5));
    chk("t4_second_rs1", BW'(issue_rs1_value), BW'(32'h500));
    cycle();
    fu_available = 1'b0;
    #1;
    chk("t4_count_six", BW'(count), BW'(6));
    cycle();

    // Flush beats dispatch and issue
    flush = 1'b1;
    cycle();
    idle();
    drive_op(4'b0001, 1'b0, 1'b1, 6'd0, 32'd3, 1'b1, 6'd0, 32'd4, 6'd1, 6'd1);
    cycle();
    drive_op(4'b0001, 1'b0, 1'b0, 6'd50, 32'd0, 1'b1, 6'd0, 32'd4, 6'd2, 6'd2);
    cycle();
    drive_op(4'b0001, 1'b0, 1'b0, 6'd51, 32'd0, 1'b1, 6'd0, 32'd4, 6'd3, 6'd3);
    cycle();
    drive_op(4'b1011, 1'b1, 1'b1, 6'd0, 32'd8, 1'b0, 6'd52, 32'd0, 6'd4, 6'd4);
    flush = 1'b1; fu_available = 1'b1;
    #1;
    chk("t5_flush_no_issue", BW'(issue_write_enable), '0);
    cycle();
    idle();
    #1;
    chk("t5_flush_count", BW'(count), '0);
    cycle();

    // Asynchronous reset in the middle of a wait
    fu_available = 1'b0;
    drive_op(4'b1111, 1'b0, 1'b1, 6'd0, 32'd9, 1'b1, 6'd0, 32'd9, 6'd7, 6'd7);
    cycle();
    idle();
    #2;
    fu_available = 1'b1; reset_n = 1'b0;
    #1;
    chk("t6_reset_count", BW'(count), '0);
    chk("t6_reset_ready", BW'(dispatch_ready), BW'(1));
    chk("t6_reset_we", BW'(issue_write_enable), '0);
    chk("t6_reset_fields", dut_bundle, '0);
    model_q.delete();
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cycle();

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      idle();
      fu_available  = ($urandom_range(0, 9) < 7);
      flush         = ($urandom_range(0, 39) == 0);
      wakeup_active = 2'($urandom_range(0, 3));
      wakeup_tag    = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
      wakeup_value  = {$urandom, $urandom};
      if (model_q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
        drive_op(legal_ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
                 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

In-order-allocated, oldest-first-issue reservation station placed directly upstream of the ALU functional unit. It accepts renamed ALU ops from dispatch and holds them until both source operands are available. Operands are captured from two wakeup buses: the FU result bus and the load-result bus. When the FU reports `is_available`, it issues the oldest ready op through the FU's issue interface.

## Interface
- `DEPTH`, 8: number of entries, ≥2.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of all entries (mispredict recovery).
- `dispatch_valid`  in  1  dispatch presents an op this cycle.
- `dispatch_ready`  out  1  `count != DEPTH`.
- `dispatch_ALUControl`  in  4  op code.
- `dispatch_ALUSrc`  in  1  1 means rs1 OP imm; rs2 is unused.
- `dispatch_is_for_lsq`  in  1  passed through to the FU.
- `dispatch_imm`  in  32  immediate.
- `dispatch_rs1_ready`, `dispatch_rs2_ready`  in  1 each  operand value already valid.
- `dispatch_rs1_tag`, `dispatch_rs2_tag`  in  6 each  producer tag when not ready.
- `dispatch_rs1_value`, `dispatch_rs2_value`  in  32 each  value when ready.
- `dispatch_tag_to_output`  in  6  destination physical tag.
- `dispatch_rob_index`  in  6  ROB slot.
- `wakeup_active`  in  2  per-bus valid. Bus 0 is the FU result; bus 1 is the load result.
- `wakeup_tag`  in  12  bus b tag at [6b+5:6b].
- `wakeup_value`  in  64  bus b value at [32b+31:32b].
- `fu_available`  in  1  FU `is_available`.
- `issue_write_enable`  out  1  drives FU `write_enable`.
- `issue_ALUControl` (4), `issue_ALUSrc` (1), `issue_is_for_lsq` (1), `issue_imm` (32), `issue_rs1_value` (32), `issue_rs2_value` (32), `issue_tag_to_output` (6), `issue_rob_index` (6)  out  FU issue fields.
- `count`  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Storage is a compacted queue. Entries 0..count-1 are valid, and entry 0 is the oldest.
- Each entry holds:
  - all dispatch fields;
  - per-operand ready bit, tag and value.
- If ALUSrc=1, rs2 is stored as ready regardless of `dispatch_rs2_ready`.
- An entry is eligible when both of its operands are ready.
- **Select:** issue the lowest-index eligible entry. `issue_write_enable = fu_available & any_eligible & !flush`.
  - Issue outputs are combinational from registered entry state only. There is no wakeup-to-issue bypass.
  - While `issue_write_enable` is 0, all `issue_*` data outputs are 0.
- **Remove:** on an issue edge, the issued entry leaves the queue. Entries above it shift down by one, preserving order.
- **Allocate:** an op is accepted when `dispatch_valid & dispatch_ready`.
  - It is written at index `count`, or at `count-1` if an issue also occurs that edge.
  - `count` gets +1 on dispatch only, -1 on issue only, and is unchanged on both or neither.
- **Capture:** for every valid, not-ready operand whose tag equals an active bus tag, store that bus value and set ready at the edge.
  - If both buses match, bus 0 wins.
  - Capture also applies to an operand being dispatched that same cycle (dispatch/wakeup race), so no broadcast is missed.
  - Capture and shift in the same edge compose: a shifted entry keeps its captured value.
- **Flush:** empties the queue (`count=0`) at the edge. Flush overrides dispatch and issue.
- **Checks (simulation `$fatal`):**
  - dispatch while `dispatch_ready`=0;
  - dispatched ALUControl not in {0000, 0001, 0010, 0011, 1011, 1111}.

## Timing
- **Reset** (`reset_n` low, immediate, asynchronous):
  - `count`=0, all entries invalid;
  - `dispatch_ready`=1;
  - `issue_write_enable`=0 and every `issue_*` output 0.
- **Dispatch→issue:**
  - An op dispatched with both operands ready is eligible the next cycle. It issues that cycle if `fu_available`=1.
  - The minimum in-station residency is 1 cycle.
- **Wakeup→issue:** an operand captured at edge N makes the entry eligible in cycle N+1.
- The FU latches the issue on the same edge the station removes the entry. The FU asserts `is_available` during its own completion cycle, so back-to-back issue every cycle is legal.
- **Full:** `dispatch_ready`=0 while `count=DEPTH`, even if an issue occurs that cycle. There is no same-cycle free-slot reuse.
- **Empty:** no issue; outputs are 0.

## Test plan
- **Ready-operand issue:** reset, dispatch ADD (0010) with rs1=5, rs2=7 both ready, tag 9, rob 3, `fu_available`=1 → the next cycle shows `issue_write_enable`=1 with rs1 5, rs2 7, tag 9, rob 3; `count` returns to 0.
- **Wakeup capture:** dispatch OR with rs1 waiting on tag 12, then drive bus 1 active with tag 12 and value 0xF0 → issue occurs exactly one cycle after the broadcast with `issue_rs1_value`=0xF0.
- **Dispatch/wakeup race:** dispatch with rs2 tag 20 not ready while bus 0 broadcasts tag 20, value 0x33 in the same cycle → the entry issues next cycle with rs2=0x33.
- **Oldest-first and shift:** fill to DEPTH with op k's rs1 waiting on tag 40+k, k=0..7, hold `fu_available`=0, and check `dispatch_ready`=0. Then broadcast tags 40+5 then 40+2 and raise `fu_available` → entries issue in order 2, 5, and `count` drops 8→6.
- **Flush and reset:** with 3 entries and a simultaneous dispatch and flush → `count`=0 next cycle and no issue. Asserting `reset_n`=0 mid-wait clears all outputs immediately.
